// File: rtl/paillier_pkg.sv
// Shared widths, timing constants and FSM state type for the Paillier decryptor.
package paillier_pkg;
  localparam int W             = 64;
  localparam int MW            = 32;
  localparam int MODMUL_CYCLES = 66;
  localparam int DIV_CYCLES    = 64;
  localparam int LATENCY       = 8580;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    EXP_SQ,
    EXP_MUL,
    DIV,
    MU_MUL,
    DONE
  } state_t;
endpackage

// File: rtl/paillier_decrypt_mod_mult.sv
// Interleaved shift-add (Blakley) modular multiplier: r = a*b mod mod.
// Scans a MSB-first, one bit per cycle; b must be below mod.
// go is sampled on an edge, the last of 64 iterations lands 64 edges later,
// and rdy is high for the single cycle that follows (65 cycles after go).
module mod_mult
  import paillier_pkg::*;
#(
  parameter int W = paillier_pkg::W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] mod,
  output logic [W-1:0] r,
  output logic         rdy
);
  localparam int CW = $clog2(MODMUL_CYCLES);

  logic [W+1:0]  acc;
  logic [W+1:0]  t;
  logic [W+1:0]  nxt;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_r;
  logic [W-1:0]  mod_r;
  logic [CW-1:0] cnt;

  // one Blakley step: 2*acc + bit*b is below 3*mod, so at most two subtractions
  always_comb begin
    nxt = '0;
    t   = (acc << 1) + (a_sh[W-1] ? {2'b00, b_r} : '0);
    if (t >= {1'b0, mod_r, 1'b0})
      nxt = t - {1'b0, mod_r, 1'b0};
    else if (t >= {2'b00, mod_r})
      nxt = t - {2'b00, mod_r};
    else
      nxt = t;
  end

  assign r = acc[W-1:0];

  // operand capture on go, then iterate under a down-counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      a_sh  <= '0;
      b_r   <= '0;
      mod_r <= '0;
      cnt   <= '0;
      rdy   <= 1'b0;
    end else if (go) begin
      acc   <= '0;
      a_sh  <= a;
      b_r   <= b;
      mod_r <= mod;
      cnt   <= CW'(MODMUL_CYCLES - 2);
      rdy   <= 1'b0;
    end else if (cnt != '0) begin
      acc   <= nxt;
      a_sh  <= a_sh << 1;
      cnt   <= cnt - 1'b1;
      rdy   <= (cnt == CW'(1));
    end else begin
      rdy   <= 1'b0;
    end
  end
endmodule

// File: rtl/paillier_decrypt.sv
// Paillier decryption: m = L(c^lambda mod n^2) * mu mod n, L(x) = (x-1)/n.
// Constant-time exponentiation over all W bits of lambda, inline restoring
// divider, one shared modular multiplier.
//   state   | meaning
//   IDLE    | waiting for start, operands captured on accept
//   PREP    | nsq = n*n, operand validity check
//   EXP_SQ  | acc = acc*acc mod nsq
//   EXP_MUL | t = acc*c mod nsq, kept only when the lambda bit is 1
//   DIV     | quotient = (acc-1)/n, one bit per cycle
//   MU_MUL  | quotient*mu mod n
//   DONE    | result presented, wait for start low
module paillier_decrypt
  import paillier_pkg::*;
#(
  parameter int W  = paillier_pkg::W,
  parameter int MW = paillier_pkg::MW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  c,
  input  logic [W-1:0]  n,
  input  logic [W-1:0]  lambda,
  input  logic [W-1:0]  mu,
  output logic [MW-1:0] m,
  output logic          done,
  output logic          err
);
  localparam int IW = $clog2(W);
  localparam int DW = $clog2(DIV_CYCLES + 1);

  state_t        state;
  logic [W-1:0]  c_r, n_r, lam_r, mu_r;
  logic [W-1:0]  nsq, acc, dvd, rem, quo;
  logic [IW-1:0] idx;
  logic [DW-1:0] dcnt;
  logic          go;
  logic [MW-1:0] res;
  logic          res_err;

  logic [W-1:0]  mm_a, mm_b, mm_mod, mm_r;
  logic          mm_rdy;
  logic [W-1:0]  nn, accn, rem_nxt;
  logic [W:0]    rem_sh;
  logic          qbit, bad;

  mod_mult #(.W(W)) u_mm (
    .clk (clk),
    .rst (rst),
    .go  (go),
    .a   (mm_a),
    .b   (mm_b),
    .mod (mm_mod),
    .r   (mm_r),
    .rdy (mm_rdy)
  );

  // multiplier operand select; the scanned operand may be any value
  always_comb begin
    mm_a   = acc;
    mm_b   = acc;
    mm_mod = nsq;
    case (state)
      EXP_MUL: mm_b = c_r;
      MU_MUL: begin
        mm_a   = quo;
        mm_b   = mu_r;
        mm_mod = n_r;
      end
      default: ;
    endcase
  end

  // operand check, exponent bit select and one restoring-division step
  always_comb begin
    nn      = n_r * n_r;
    bad     = (n_r == '0) || ((n_r >> MW) != '0) || (c_r >= nn) || (mu_r >= n_r);
    accn    = lam_r[idx] ? mm_r : acc;
    rem_sh  = {rem, dvd[W-1]};
    rem_nxt = rem_sh[W-1:0];
    qbit    = 1'b0;
    if (rem_sh >= {1'b0, n_r}) begin
      rem_nxt = W'(rem_sh - {1'b0, n_r});
      qbit    = 1'b1;
    end
  end

  // sequencing FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      c_r     <= '0;
      n_r     <= '0;
      lam_r   <= '0;
      mu_r    <= '0;
      nsq     <= '0;
      acc     <= '0;
      dvd     <= '0;
      rem     <= '0;
      quo     <= '0;
      idx     <= '0;
      dcnt    <= '0;
      go      <= 1'b0;
      res     <= '0;
      res_err <= 1'b0;
      m       <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      go <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            c_r   <= c;
            n_r   <= n;
            lam_r <= lambda;
            mu_r  <= mu;
            state <= PREP;
          end
        end
        PREP: begin
          nsq <= nn;
          if (bad) begin
            res     <= '0;
            res_err <= 1'b1;
            state   <= DONE;
          end else begin
            acc   <= W'(1);
            idx   <= IW'(W - 1);
            go    <= 1'b1;
            state <= EXP_SQ;
          end
        end
        EXP_SQ: begin
          if (mm_rdy) begin
            acc   <= mm_r;
            go    <= 1'b1;
            state <= EXP_MUL;
          end
        end
        EXP_MUL: begin
          if (mm_rdy) begin
            acc <= accn;
            if (idx == '0) begin
              dvd   <= accn - W'(1);
              rem   <= '0;
              quo   <= '0;
              dcnt  <= DW'(DIV_CYCLES);
              state <= DIV;
            end else begin
              idx   <= idx - 1'b1;
              go    <= 1'b1;
              state <= EXP_SQ;
            end
          end
        end
        DIV: begin
          dvd  <= dvd << 1;
          rem  <= rem_nxt;
          quo  <= {quo[W-2:0], qbit};
          dcnt <= dcnt - 1'b1;
          if (dcnt == DW'(1)) begin
            go    <= 1'b1;
            state <= MU_MUL;
          end
        end
        MU_MUL: begin
          if (mm_rdy) begin
            res     <= mm_r[MW-1:0];
            res_err <= 1'b0;
            state   <= DONE;
          end
        end
        DONE: begin
          if (!done) begin
            done <= 1'b1;
            m    <= res;
            err  <= res_err;
          end else if (!start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/paillier_decrypt.md
PAILLIER_DECRYPT -- requirements
Module: paillier_decrypt

Interface
REQ-001 Parameter W, default 64, datapath width of c, n, lambda, mu.
REQ-002 Parameter MW, default 32, plaintext width; n SHALL be below 2^MW so that n^2 fits in W bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  level request; an operation begins when start=1 in IDLE.
REQ-006 c  input  W  ciphertext, required c < n^2.
REQ-007 n  input  W  public modulus.
REQ-008 lambda  input  W  private exponent, lcm(p-1,q-1).
REQ-009 mu  input  W  private factor, lambda^-1 mod n, required mu < n.
REQ-010 m  output  MW  recovered plaintext.
REQ-011 done  output  1  result valid; held high until start=0.
REQ-012 err  output  1  invalid operands; valid while done=1.

Function
REQ-013 Computes m = L(c^lambda mod n^2) * mu mod n, with L(x) = (x-1)/n (integer quotient).
REQ-014 Inputs c, n, lambda and mu are registered on the edge that accepts start; later input changes have no effect until the next operation.
REQ-015 FSM states: IDLE, PREP, EXP_SQ, EXP_MUL, DIV, MU_MUL, DONE.
REQ-016 IDLE->PREP when start=1; PREP computes nsq = n*n (W bits) in one cycle and checks the operands.
REQ-017 PREP->DONE with err=1 and m=0 when n==0, n >= 2^MW, c >= nsq, or mu >= n; done rises on the 2nd edge after start is sampled.
REQ-018 Otherwise PREP->EXP_SQ with acc=1 and bit index 63.
REQ-019 Exponentiation is constant-time: all W bits of lambda are scanned MSB-first.
REQ-020 Each exponentiation bit runs EXP_SQ (acc=acc*acc mod nsq), then EXP_MUL (t=acc*c mod nsq). acc takes t only when the lambda bit is 1; the multiply is always executed.
REQ-021 Every modular-multiply phase occupies exactly 66 cycles: 1 launch cycle plus 65 wait cycles.
REQ-022 After bit 0, EXP_MUL->DIV: restoring division of (acc-1) by n, exactly 64 cycles; the quotient fits in MW bits.
REQ-023 DIV->MU_MUL: (quotient*mu) mod n, 66 cycles; then ->DONE, where m is loaded and done=1, err=0.
REQ-024 Valid-operand latency: done rises exactly 8580 cycles after the edge that sampled start (1 PREP + 128x66 + 64 + 66 + 1).
REQ-025 DONE->IDLE when start=0; done, m and err hold their values until that edge; done falls on that edge.
REQ-026 start=1 outside IDLE is ignored; start held high through DONE does not retrigger.
REQ-027 lambda=0 yields acc=1, L=0 and m=0 with err=0 and normal latency.
REQ-028 Modular-multiply accumulators are W+2 bits wide; no intermediate result may be truncated before reduction.

Reset
REQ-029 rst=1 asynchronously forces state IDLE, m=0, done=0, err=0, and clears acc, nsq, all operand registers and the sub-module state.
REQ-030 Reset mid-operation aborts the operation with no partial result visible; with start=1 after rst falls, a fresh operation starts on the next edge.

Structure
REQ-031 Package paillier_pkg SHALL hold W, MW, the FSM state typedef, MODMUL_CYCLES=66, DIV_CYCLES=64 and LATENCY=8580.
REQ-032 Sub-module mod_mult: interleaved shift-add (Blakley) multiplier with ports clk, rst, go, a, b, mod, r, rdy; rdy pulses 65 cycles after go; instantiated once and shared by all multiply phases.
REQ-033 The divider is inline in paillier_decrypt; no other sub-modules.

Verification
REQ-034 n=3233, lambda=780, mu=1173, c=397660, start held high -> done at +8580 cycles, m=123, err=0.
REQ-035 Same keys, c=1 -> m=0; c=10449057 -> m=3232; err=0 in both cases.
REQ-036 Same keys, c=10452289 (=n^2) -> done at +2 cycles, err=1, m=0.
REQ-037 n=0 -> err=1; mu=3233 -> err=1; done at +2 cycles in both cases.
REQ-038 rst pulsed at cycle 4000 of the REQ-034 case -> done=0 and m=0 immediately; the restarted operation returns m=123 at +8580 cycles.
REQ-039 start held high through DONE -> no second operation; start toggled low then high -> second result at +8580 cycles.
